// File: rtl/ppc_pkg.sv
// Shared types and helpers for the ping-pong counter input conditioner.
package ppc_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } flip_state_e;

   // Counter width for a divider that counts 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ppc_input_conditioner_debounce.sv
// Button synchronizer, sampled debouncer and rising-edge one-pulse.
module debounce_onepulse
   import ppc_pkg::*;
#(
   parameter int DB_DIV = 100_000,
   parameter int DB_LEN = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_press
);

   logic [1:0]        r_sync;
   logic [DB_LEN-1:0] r_shift;
   logic              r_db_hold;
   logic              w_samp;
   logic              w_db;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
      end
   end

   generate
      if (DB_DIV == 1) begin : g_samp_every
         assign w_samp = 1'b1;
      end else begin : g_samp_div
         localparam int LP_W = cnt_width(DB_DIV);
         localparam logic [LP_W-1:0] LP_MAX = LP_W'(DB_DIV - 1);
         logic [LP_W-1:0] r_cnt;

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_cnt <= '0;
            end else if (r_cnt == LP_MAX) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + LP_W'(1);
            end
         end

         assign w_samp = (r_cnt == LP_MAX);
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shift   <= '0;
         r_db_hold <= 1'b0;
      end else begin
         if (w_samp) begin
            r_shift <= {r_shift[DB_LEN-2:0], r_sync[1]};
         end
         r_db_hold <= w_db;
      end
   end

   // Level flips only on a unanimous window; mixed windows keep the last level.
   assign w_db    = (&r_shift) | (r_db_hold & (|r_shift));
   assign o_press = w_db & ~r_db_hold;

endmodule

// File: rtl/ppc_input_conditioner.sv
// Run-switch synchronizer, step divider and tick-aligned flip request FSM.
module ppc_input_conditioner
   import ppc_pkg::*;
#(
   parameter int TICK_DIV = 25_000_000,
   parameter int DB_DIV   = 100_000,
   parameter int DB_LEN   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_flip,
   input  logic sw_run,
   output logic run,
   output logic enable_out,
   output logic flip_out,
   output logic flip_pending
);

   localparam int LP_TW = cnt_width(TICK_DIV);
   localparam logic [LP_TW-1:0] LP_TMAX = LP_TW'(TICK_DIV - 1);

   logic [1:0]       r_run_sync;
   logic [LP_TW-1:0] r_tcnt;
   logic             r_tick;
   logic             r_flip;
   flip_state_e      r_state;
   flip_state_e      w_state_next;
   logic             w_press;
   logic             w_tick_set;
   logic             w_flip_next;

   debounce_onepulse #(
      .DB_DIV (DB_DIV),
      .DB_LEN (DB_LEN)
   ) u_debounce (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_btn   (btn_flip),
      .o_press (w_press)
   );

   assign w_tick_set = r_run_sync[1] && (r_tcnt == LP_TMAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_run_sync <= '0;
         r_tcnt     <= '0;
         r_tick     <= 1'b0;
         r_flip     <= 1'b0;
      end else begin
         r_run_sync <= {r_run_sync[0], sw_run};
         if (!r_run_sync[1] || w_tick_set) begin
            r_tcnt <= '0;
         end else begin
            r_tcnt <= r_tcnt + LP_TW'(1);
         end
         r_tick <= w_tick_set;
         r_flip <= w_flip_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A press landing on the tick-setting cycle rides that tick directly.
   always_comb begin
      w_state_next = r_state;
      w_flip_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_press) begin
               if (w_tick_set) begin
                  w_flip_next = 1'b1;
               end else begin
                  w_state_next = ST_PENDING;
               end
            end
         end
         ST_PENDING: begin
            if (w_tick_set) begin
               w_flip_next  = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign run          = r_run_sync[1];
   assign enable_out   = r_tick;
   assign flip_out     = r_flip;
   assign flip_pending = (r_state == ST_PENDING);

endmodule

// File: tb/tb_ppc_input_conditioner.sv
// Bench for ppc_input_conditioner: two instances (TICK_DIV 4 and 20) share stimulus.
module tb_ppc_input_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_flip = 1'b0;
   logic sw_run = 1'b0;

   logic run4, en4, fl4, pd4;
   logic run20, en20, fl20, pd20;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ppc_input_conditioner #(.TICK_DIV(4), .DB_DIV(1), .DB_LEN(3)) dut4 (
      .clk          (clk),
      .rst          (rst),
      .btn_flip     (btn_flip),
      .sw_run       (sw_run),
      .run          (run4),
      .enable_out   (en4),
      .flip_out     (fl4),
      .flip_pending (pd4)
   );

   ppc_input_conditioner #(.TICK_DIV(20), .DB_DIV(1), .DB_LEN(3)) dut20 (
      .clk          (clk),
      .rst          (rst),
      .btn_flip     (btn_flip),
      .sw_run       (sw_run),
      .run          (run20),
      .enable_out   (en20),
      .flip_out     (fl20),
      .flip_pending (pd20)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      sw_run = 1'b0;
      btn_flip = 1'b0;
      repeat (n) cyc();
      rst = 1'b0;
   endtask

   // Reference model: run is sw_run two edges late, ticks come every TICK_DIV-th
   // cycle of an unbroken run streak, the button level changes only on a full
   // window of equal samples, and a press rides the next tick.
   localparam int DBL = 3;
   int   tds[2] = '{4, 20};
   logic m_sw_p = 1'b0, m_btn_p = 1'b0, m_rst_p = 1'b0;
   logic m_run = 1'b0, m_bs = 1'b0, m_db = 1'b0, m_press = 1'b0;
   logic m_hist[$];
   int   m_streak = 0;
   logic m_tick[2] = '{1'b0, 1'b0};
   logic m_flip[2] = '{1'b0, 1'b0};
   logic m_pend[2] = '{1'b0, 1'b0};
   logic chk_en = 1'b0;

   always @(posedge clk) begin : model
      logic run_o, bs_o, press_o, all1, all0, db_n, tk;
      int   streak_o;
      run_o    = m_run;
      bs_o     = m_bs;
      press_o  = m_press;
      streak_o = m_streak;
      if (rst || m_rst_p) begin
         m_run = 1'b0;
         m_bs  = 1'b0;
      end else begin
         m_run = m_sw_p;
         m_bs  = m_btn_p;
      end
      if (rst) begin
         m_hist = {};
         for (int i = 0; i < DBL; i++) m_hist.push_back(1'b0);
         m_db    = 1'b0;
         m_press = 1'b0;
      end else begin
         m_hist.push_back(bs_o);
         void'(m_hist.pop_front());
         all1 = 1'b1;
         all0 = 1'b1;
         foreach (m_hist[i]) begin
            if (m_hist[i]) all0 = 1'b0;
            else all1 = 1'b0;
         end
         db_n    = all1 ? 1'b1 : (all0 ? 1'b0 : m_db);
         m_press = db_n & ~m_db;
         m_db    = db_n;
      end
      m_streak = m_run ? streak_o + 1 : 0;
      for (int k = 0; k < 2; k++) begin
         tk = !rst && run_o && (streak_o > 0) && ((streak_o % tds[k]) == 0);
         m_flip[k] = tk && (m_pend[k] || press_o);
         m_pend[k] = rst ? 1'b0 : (tk ? 1'b0 : (m_pend[k] || press_o));
         m_tick[k] = tk;
      end
      m_sw_p  = sw_run;
      m_btn_p = btn_flip;
      m_rst_p = rst;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_run4", run4, m_run);
         chk("model_en4", en4, m_tick[0]);
         chk("model_fl4", fl4, m_flip[0]);
         chk("model_pd4", pd4, m_pend[0]);
         chk("model_run20", run20, m_run);
         chk("model_en20", en20, m_tick[1]);
         chk("model_fl20", fl20, m_flip[1]);
         chk("model_pd20", pd20, m_pend[1]);
      end
   end

   typedef struct {
      logic rst, sw, btn;
      logic run, en, fl, pd;
   } vec_t;

   vec_t tbl[17];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t, cnt, fcnt, bad, last, pd_low;

      for (int i = 0; i < 17; i++) begin
         tbl[i] = '{rst: (i < 3), sw: 1'b1, btn: (i < 8),
                    run: (i >= 4), en: (i == 8 || i == 12 || i == 16),
                    fl: (i == 8), pd: 1'b0};
      end
      for (int i = 0; i < DBL; i++) m_hist.push_back(1'b0);
      chk_en = 1'b1;

      // Reset with inputs held high, then a press that lands on the first tick
      for (int i = 0; i < 17; i++) begin
         rst = tbl[i].rst;
         sw_run = tbl[i].sw;
         btn_flip = tbl[i].btn;
         cyc();
         chk($sformatf("tbl%0d_run", i), run4, tbl[i].run);
         chk($sformatf("tbl%0d_en", i), en4, tbl[i].en);
         chk($sformatf("tbl%0d_fl", i), fl4, tbl[i].fl);
         chk($sformatf("tbl%0d_pd", i), pd4, tbl[i].pd);
      end

      // Free run: 10 ticks, 4 apart, in the 40 cycles after run rises
      do_reset(2);
      sw_run = 1'b1;
      t = 0;
      while (!run4 && t < 6) begin cyc(); t++; end
      chk("free_run_latency", t, 2);
      cnt = 0; fcnt = 0; bad = 0; last = 0;
      for (int i = 1; i <= 40; i++) begin
         cyc();
         if (en4) begin
            if (i - last != 4) bad++;
            last = i;
            cnt++;
         end
         if (fl4) fcnt++;
      end
      chk("free_run_ticks", cnt, 10);
      chk("free_run_spacing", bad, 0);
      chk("free_run_flips", fcnt, 0);

      // Bounce: 1,0,1,0,1 then 12 cycles high, then released
      fcnt = 0; bad = 0;
      for (int i = 0; i < 29; i++) begin
         if (i < 5) btn_flip = ~i[0];
         else btn_flip = (i < 17);
         cyc();
         if (fl4) begin
            fcnt++;
            if (!en4) bad++;
         end
      end
      chk("bounce_flips", fcnt, 1);
      chk("bounce_aligned", bad, 0);

      // Merge on the TICK_DIV=20 instance: two presses inside one period
      t = 0;
      while (!en20 && t < 25) begin cyc(); t++; end
      chk("merge_tick_found", en20, 1);
      fcnt = 0; last = -1;
      for (int i = 1; i <= 42; i++) begin
         btn_flip = (i <= 4) || (i >= 9 && i <= 12);
         cyc();
         if (fl20) begin fcnt++; last = i; end
      end
      btn_flip = 1'b0;
      chk("merge_flips", fcnt, 1);
      chk("merge_flip_cycle", last, 20);

      // Pause: press while stopped, flip rides the first tick after run returns
      do_reset(2);
      btn_flip = 1'b1;
      repeat (4) cyc();
      btn_flip = 1'b0;
      pd_low = 0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (i >= 3 && !pd4) pd_low++;
      end
      chk("pause_pending_held", pd_low, 0);
      sw_run = 1'b1;
      t = 0;
      while (!run4 && t < 6) begin cyc(); t++; end
      chk("pause_run_rise", run4, 1);
      chk("pause_pd_at_run", pd4, 1);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk($sformatf("pause_en_%0d", k), en4, (k == 4));
         chk($sformatf("pause_fl_%0d", k), fl4, (k == 4));
      end
      chk("pause_pd_cleared", pd4, 0);

      // Reset while a flip is pending discards it
      do_reset(2);
      sw_run = 1'b1;
      t = 0;
      while (!en20 && t < 30) begin cyc(); t++; end
      chk("rstpend_tick_found", en20, 1);
      btn_flip = 1'b1;
      repeat (4) cyc();
      btn_flip = 1'b0;
      t = 0;
      while (!pd20 && t < 10) begin cyc(); t++; end
      chk("rstpend_pending", pd20, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rstpend_pd20_cleared", pd20, 0);
      chk("rstpend_pd4_cleared", pd4, 0);
      fcnt = 0; cnt = 0;
      for (int i = 0; i < 45; i++) begin
         cyc();
         if (fl20 || fl4) fcnt++;
         if (en4) cnt++;
      end
      chk("rstpend_no_flip", fcnt, 0);
      chk("rstpend_ticks_resume", (cnt >= 9), 1);

      // Random switch/button activity with rare resets, checked by the model
      do_reset(2);
      begin
         int sw_hold = 0;
         int btn_hold = 0;
         for (int c = 0; c < 1500; c++) begin
            if (sw_hold == 0) begin
               sw_run = 1'($urandom_range(0, 1));
               sw_hold = $urandom_range(1, 60);
            end else begin
               sw_hold--;
            end
            if (btn_hold == 0) begin
               btn_flip = 1'($urandom_range(0, 1));
               btn_hold = $urandom_range(1, 8);
            end else begin
               btn_hold--;
            end
            rst = ($urandom_range(0, 299) == 0);
            cyc();
         end
      end
      rst = 1'b0;
      cyc();
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ppc_input_conditioner.md
# ppc_input_conditioner

Front-end stage for the parameterized ping-pong counter. It turns a raw push-button and a raw run switch into clean, clock-synchronous control strobes. It emits a one-cycle `enable_out` step tick at a programmable rate, plus a one-cycle `flip_out` that is always aligned with a tick, so a button press is never lost between steps. Its outputs connect directly to the counter's `enable` and `flip` inputs.

## Interface
Parameters:
- `TICK_DIV`, default 25_000_000: clock cycles per counter step; legal range ≥ 2.
- `DB_DIV`, default 100_000: clock cycles between debounce samples; legal range ≥ 1.
- `DB_LEN`, default 4: number of consecutive equal samples needed to change the debounced level; legal range ≥ 2.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: reset. Reset is synchronous and active-high.
- `btn_flip`, in, 1: raw, asynchronous, bouncy flip button (1 = pressed).
- `sw_run`, in, 1: raw, asynchronous run switch.
- `run`, out, 1: synchronized `sw_run`.
- `enable_out`, out, 1: one-cycle step tick; connects to the counter's `enable`.
- `flip_out`, out, 1: one-cycle flip request; only ever high in a cycle where `enable_out` is also high.
- `flip_pending`, out, 1: a press has been accepted and not yet issued.

## Operation
- **Synchronizers:** `btn_flip` and `sw_run` each pass through a 2-flop synchronizer. `run` is the second flop of the `sw_run` chain.
- **Sample strobe:** a divider counts 0..DB_DIV-1 continuously and asserts `samp` for one cycle on wrap. When DB_DIV=1, `samp` is high every cycle.
- **Debounce:**
  - On `samp`, the synchronized button value shifts into a DB_LEN-bit register.
  - The debounced level `db` goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds.
- **One-pulse:** `press` is high for exactly one cycle on each 0→1 transition of `db`.
- **Step divider:** counter `tcnt`, width clog2(TICK_DIV).
  - If `run`=0, `tcnt`←0.
  - If `run`=1 and `tcnt`=TICK_DIV-1, `tcnt`←0 and the registered `tick`←1.
  - Otherwise `tcnt` increments.
  - `enable_out`=`tick`.
- **Flip FSM:** states are IDLE and PENDING; `flip_pending` = (state==PENDING).
  - IDLE, `press` and no tick in the same cycle → PENDING.
  - IDLE, `press` coinciding with the cycle that sets `tick` → the flip is issued on that tick and the state stays IDLE.
  - PENDING, on the cycle that sets `tick` → `flip_out`←1 together with `enable_out`, then IDLE.
  - PENDING, further presses are merged: at most one flip is issued per tick.
  - `run`=0 does not clear PENDING. The flip is issued on the first tick after `run` returns.
- **Reset:** clears every state element, including both synchronizers, the debounce shift register (all 0), `db`, both dividers, the FSM (IDLE) and both registered outputs.

## Timing
- **Reset values:** `run`=0, `enable_out`=0, `flip_out`=0, `flip_pending`=0.
- **`sw_run`→`run`:** 2 cycles.
- **First tick:** `enable_out` first rises exactly TICK_DIV cycles after the first cycle in which `run`=1. After that it pulses every TICK_DIV cycles.
- **Button to `db`:** 2 synchronizer cycles plus DB_LEN sample strobes of stable input. `press` is high in the same cycle `db` rises.
- **Press to flip:**
  - `flip_pending` rises the cycle after `press`.
  - `flip_out` appears on the next `enable_out` pulse.
  - Worst-case press→`flip_out` is TICK_DIV cycles while running.
- **Output registers:** `enable_out` and `flip_out` are registered, with no combinational path from any input.
- **Release:** a release (1→0) produces no event.
- **Reset mid-operation:** a pending flip is discarded and the divider restarts from 0.

## Structure
- **Package `ppc_pkg`:** holds the flip FSM state typedef (IDLE, PENDING) and the width helper for the divider counters.
- **Sub-module `debounce_onepulse`:** contains the synchronizer, sample strobe, shift register, `db` level and `press` output, parameterized by DB_DIV and DB_LEN. It is instantiated once.
- **Top level:** contains the `sw_run` synchronizer, the step divider and the flip FSM.

## Test plan
All scenarios use TICK_DIV=4, DB_DIV=1, DB_LEN=3 unless noted.
- **Reset:** hold `rst`=1 for 3 cycles with `sw_run`=1 and `btn_flip`=1 → all outputs 0 throughout. After release, `enable_out` first rises 4 cycles after `run`=1.
- **Free run:** `sw_run`=1 for 40 cycles → 10 `enable_out` pulses spaced 4 cycles apart, and `flip_out` stays 0.
- **Bounce:** `btn_flip` pattern 1,0,1,0,1 followed by 1 for 12 cycles → exactly one `press`, exactly one `flip_out`, coincident with an `enable_out` pulse.
- **Merge:** two clean presses, each stable for 4 cycles, inside one tick period with TICK_DIV=20 → a single `flip_out`.
- **Pause:** press while `run`=0, wait 30 cycles, then set `sw_run`=1 → `flip_pending` stays 1 during the pause, and `flip_out` fires on the first tick, 4 cycles after `run` rises.
- **Reset mid-pending:** press while running, then assert `rst` for 1 cycle while `flip_pending`=1 → `flip_pending`=0 and no `flip_out` on the following ticks.
